id_ex_operand_stage: RTL

Decode-to-execute pipeline stage of the RV32I core. It drives the register-file read addresses and takes the combinational read values. It resolves each source operand by bypassing from EX, MEM and WB, and detects load-use hazards. Resolved operands and control are registered into the ID/EX register behind a valid/ready handshake, with flush and a stall performance counter.

---
 rtl/rv_pipe_pkg.sv | 21 ++
 rtl/operand_bypass.sv | 48 ++++
 rtl/id_ex_operand_stage.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared RV32I pipeline definitions: datapath widths, forwarding-source
// selector and the bundle each bypass producer presents.
package rv_pipe_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_EX  = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic                  wen;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } fwd_src_t;

endpackage

// File: rtl/operand_bypass.sv
// Resolves one source operand from EX/MEM/WB bypass or the register file,
// and flags a load-use hazard when the winning source is a load still in EX.
module operand_bypass
    import rv_pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic                  used,
    input  logic [XLEN-1:0]       rf_value,
    input  fwd_src_t              ex_src,
    input  fwd_src_t              mem_src,
    input  fwd_src_t              wb_src,
    input  logic                  ex_is_load,
    output logic [XLEN-1:0]       value,
    output fwd_sel_e              sel,
    output logic                  hazard
);

    logic addr_nz;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    assign addr_nz = (addr != '0);
    assign ex_hit  = addr_nz && ex_src.wen  && (ex_src.rd  == addr);
    assign mem_hit = addr_nz && mem_src.wen && (mem_src.rd == addr);
    assign wb_hit  = addr_nz && wb_src.wen  && (wb_src.rd  == addr);

    // x0 falls through every hit test and is forced to zero below.
    always_comb begin
        sel   = FWD_RF;
        value = rf_value;
        if (ex_hit) begin
            sel   = FWD_EX;
            value = ex_src.data;
        end else if (mem_hit) begin
            sel   = FWD_MEM;
            value = mem_src.data;
        end else if (wb_hit) begin
            sel   = FWD_WB;
            value = wb_src.data;
        end else if (!addr_nz) begin
            value = '0;
        end
    end

    assign hazard = used && ex_is_load && (sel == FWD_EX);

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX stage: operand bypass, load-use stall detection and the ID/EX
// register behind a valid/ready handshake with flush and a stall counter.
module id_ex_operand_stage
    import rv_pipe_pkg::*;
#(
    parameter int CTRL_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [REG_ADDR_W-1:0] in_rs1_addr,
    input  logic [REG_ADDR_W-1:0] in_rs2_addr,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic                  in_uses_rs1,
    input  logic                  in_uses_rs2,
    input  logic                  in_is_load,
    input  logic [CTRL_W-1:0]     in_ctrl,
    output logic [REG_ADDR_W-1:0] rf_rs1_addr,
    output logic [REG_ADDR_W-1:0] rf_rs2_addr,
    input  logic [XLEN-1:0]       rf_rs1_value,
    input  logic [XLEN-1:0]       rf_rs2_value,
    input  logic                  ex_wen,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]       ex_data,
    input  logic                  mem_wen,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    input  logic                  wb_wen,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       out_rs1_value,
    output logic [XLEN-1:0]       out_rs2_value,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic                  out_is_load,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [31:0]           load_use_stalls
);

    fwd_src_t        ex_src;
    fwd_src_t        mem_src;
    fwd_src_t        wb_src;
    logic [XLEN-1:0] rs1_value_p0;
    logic [XLEN-1:0] rs2_value_p0;
    fwd_sel_e        rs1_sel_p0;
    fwd_sel_e        rs2_sel_p0;
    logic            rs1_hazard_p0;
    logic            rs2_hazard_p0;
    logic            hazard_p0;
    logic            capture_p0;
    logic [3:0]      unused_sel;

    logic                  vld_p1;
    logic [XLEN-1:0]       pc_p1;
    logic [XLEN-1:0]       rs1_value_p1;
    logic [XLEN-1:0]       rs2_value_p1;
    logic [REG_ADDR_W-1:0] rd_addr_p1;
    logic                  is_load_p1;
    logic [CTRL_W-1:0]     ctrl_p1;
    logic [31:0]           stall_cnt_p1;

    assign ex_src  = '{wen: ex_wen,  rd: ex_rd,  data: ex_data};
    assign mem_src = '{wen: mem_wen, rd: mem_rd, data: mem_data};
    assign wb_src  = '{wen: wb_wen,  rd: wb_rd,  data: wb_data};

    assign rf_rs1_addr = in_rs1_addr;
    assign rf_rs2_addr = in_rs2_addr;

    operand_bypass u_rs1_bypass (
        .addr       (in_rs1_addr),
        .used       (in_uses_rs1),
        .rf_value   (rf_rs1_value),
        .ex_src     (ex_src),
        .mem_src    (mem_src),
        .wb_src     (wb_src),
        .ex_is_load (ex_is_load),
        .value      (rs1_value_p0),
        .sel        (rs1_sel_p0),
        .hazard     (rs1_hazard_p0)
    );

    operand_bypass u_rs2_bypass (
        .addr       (in_rs2_addr),
        .used       (in_uses_rs2),
        .rf_value   (rf_rs2_value),
        .ex_src     (ex_src),
        .mem_src    (mem_src),
        .wb_src     (wb_src),
        .ex_is_load (ex_is_load),
        .value      (rs2_value_p0),
        .sel        (rs2_sel_p0),
        .hazard     (rs2_hazard_p0)
    );

    // Selector outputs are diagnostic only; this stage acts on the hazard flags.
    assign unused_sel = {rs1_sel_p0, rs2_sel_p0};

    assign hazard_p0  = in_valid && (rs1_hazard_p0 || rs2_hazard_p0);
    assign in_ready   = !hazard_p0 && !flush && (!vld_p1 || out_ready);
    assign capture_p0 = in_valid && in_ready;

    // ---- ID/EX register boundary (p0 -> p1) ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1       <= 1'b0;
            pc_p1        <= '0;
            rs1_value_p1 <= '0;
            rs2_value_p1 <= '0;
            rd_addr_p1   <= '0;
            is_load_p1   <= 1'b0;
            ctrl_p1      <= '0;
            stall_cnt_p1 <= '0;
        end else begin
            if (flush) begin
                vld_p1 <= 1'b0;
            end else if (capture_p0) begin
                vld_p1 <= 1'b1;
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
            if (capture_p0) begin
                pc_p1        <= in_pc;
                rs1_value_p1 <= rs1_value_p0;
                rs2_value_p1 <= rs2_value_p0;
                rd_addr_p1   <= in_rd_addr;
                is_load_p1   <= in_is_load;
                ctrl_p1      <= in_ctrl;
            end
            if (hazard_p0 && !flush) begin
                stall_cnt_p1 <= stall_cnt_p1 + 32'd1;
            end
        end
    end

    assign out_valid       = vld_p1;
    assign out_pc          = pc_p1;
    assign out_rs1_value   = rs1_value_p1;
    assign out_rs2_value   = rs2_value_p1;
    assign out_rd_addr     = rd_addr_p1;
    assign out_is_load     = is_load_p1;
    assign out_ctrl        = ctrl_p1;
    assign load_use_stalls = stall_cnt_p1;

endmodule
